// File: rtl/sfo_sweep_controller.sv
// sfo_sweep_controller: buffers one FFT magnitude frame, then replays it into the
// correlator once per SFO hypothesis and keeps the best-scoring hypothesis.
//
// state  | meaning
// IDLE   | one idle cycle between sweeps
// LOAD   | accepting magnitude beats into the frame RAM
// CRESET | holding correlation_reset for RESET_CYCLES
// STREAM | replaying RAM[0..n_bins-1] with correlation_update
// WAIT   | waiting for correlation_in_valid or the timeout
// NEXT   | scoring the hypothesis and stepping to the next one
// DONE   | result_valid pulse
module sfo_sweep_controller #(
  parameter int FFT_LEN_LOG2        = 9,
  parameter int POWER_WIDTH         = 16,
  parameter int RESET_CYCLES        = 2,
  parameter int TIMEOUT_CYCLES      = 128,
  parameter int SFO_INT_WIDTH       = 8,
  parameter int SFO_FRAC_WIDTH      = 8,
  parameter int FFT_SHIFT_WIDTH     = 5,
  parameter int CORR_MANTISSA_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [POWER_WIDTH-1:0]         s_mag_tdata,
  input  logic [FFT_SHIFT_WIDTH-1:0]     s_mag_exp,
  input  logic                           s_mag_tvalid,
  input  logic                           s_mag_tlast,
  output logic                           s_mag_tready,
  input  logic [SFO_INT_WIDTH-1:0]       sweep_start_int,
  input  logic [SFO_FRAC_WIDTH-1:0]      sweep_start_frac,
  input  logic [SFO_INT_WIDTH-1:0]       sweep_step_int,
  input  logic [SFO_FRAC_WIDTH-1:0]      sweep_step_frac,
  input  logic [15:0]                    sweep_count,
  output logic [SFO_INT_WIDTH-1:0]       sfo_int_part,
  output logic [SFO_FRAC_WIDTH-1:0]      sfo_frac_part,
  output logic                           correlation_reset,
  output logic                           correlation_update,
  output logic [POWER_WIDTH-1:0]         fft_mag_out,
  output logic [FFT_SHIFT_WIDTH-1:0]     fft_mag_exponent_out,
  input  logic [CORR_MANTISSA_WIDTH:0]   correlation_in,
  input  logic                           correlation_in_valid,
  output logic [SFO_INT_WIDTH-1:0]       best_sfo_int,
  output logic [SFO_FRAC_WIDTH-1:0]      best_sfo_frac,
  output logic [CORR_MANTISSA_WIDTH-1:0] best_corr,
  output logic                           best_detected,
  output logic                           result_valid,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int HW    = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
  localparam int DEPTH = 1 << FFT_LEN_LOG2;
  localparam int AW    = FFT_LEN_LOG2;
  localparam int NW    = FFT_LEN_LOG2 + 1;
  localparam int MW    = CORR_MANTISSA_WIDTH;
  localparam int RCW   = $clog2(RESET_CYCLES + 1);
  localparam int TOW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_CRESET, ST_STREAM, ST_WAIT, ST_NEXT, ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [POWER_WIDTH-1:0]     mem_q [DEPTH];
  logic [POWER_WIDTH-1:0]     mag_q;
  logic [AW-1:0]              wr_addr_q, wr_addr_d;
  logic [NW-1:0]              n_bins_q, n_bins_d;
  logic [NW-1:0]              strm_cnt_q, strm_cnt_d;
  logic [RCW-1:0]             rst_cnt_q, rst_cnt_d;
  logic [TOW-1:0]             to_cnt_q, to_cnt_d;
  logic [FFT_SHIFT_WIDTH-1:0] exp_q, exp_d;
  logic [HW-1:0]              step_q, step_d;
  logic [HW-1:0]              hyp_q, hyp_d;
  logic [HW-1:0]              best_hyp_q, best_hyp_d;
  logic [15:0]                count_q, count_d;
  logic [15:0]                hyp_idx_q, hyp_idx_d;
  logic [MW-1:0]              score_q, score_d;
  logic [MW-1:0]              best_corr_q, best_corr_d;
  logic                       flag_q, flag_d;
  logic                       best_det_q, best_det_d;
  logic                       timeout_q, timeout_d;
  logic                       upd_q, upd_d;

  logic          accept, last_beat, rd_en, to_expired, last_hyp;
  logic [AW-1:0] rd_addr;

  assign accept     = (state_q == ST_LOAD) && s_mag_tvalid;
  assign last_beat  = accept && (s_mag_tlast || (&wr_addr_q));
  assign rd_en      = (state_q == ST_STREAM) && (strm_cnt_q < n_bins_q);
  assign rd_addr    = strm_cnt_q[AW-1:0];
  assign to_expired = (to_cnt_q == TOW'(TIMEOUT_CYCLES));
  assign last_hyp   = (hyp_idx_q == count_q - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      n_bins_q    <= '0;
      strm_cnt_q  <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      exp_q       <= '0;
      step_q      <= '0;
      hyp_q       <= '0;
      best_hyp_q  <= '0;
      count_q     <= '0;
      hyp_idx_q   <= '0;
      score_q     <= '0;
      best_corr_q <= '0;
      flag_q      <= 1'b0;
      best_det_q  <= 1'b0;
      timeout_q   <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      n_bins_q    <= n_bins_d;
      strm_cnt_q  <= strm_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      exp_q       <= exp_d;
      step_q      <= step_d;
      hyp_q       <= hyp_d;
      best_hyp_q  <= best_hyp_d;
      count_q     <= count_d;
      hyp_idx_q   <= hyp_idx_d;
      score_q     <= score_d;
      best_corr_q <= best_corr_d;
      flag_q      <= flag_d;
      best_det_q  <= best_det_d;
      timeout_q   <= timeout_d;
      upd_q       <= upd_d;
    end
  end

  // Frame RAM is deliberately not reset; only its read register is.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_addr_q] <= s_mag_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset)      mag_q <= '0;
    else if (rd_en) mag_q <= mem_q[rd_addr];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_LOAD;
      ST_LOAD:   if (last_beat) state_d = (sweep_count == 16'd0) ? ST_DONE : ST_CRESET;
      ST_CRESET: if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) state_d = ST_STREAM;
      ST_STREAM: if (strm_cnt_q == n_bins_q) state_d = ST_WAIT;
      ST_WAIT:   if (correlation_in_valid || to_expired) state_d = ST_NEXT;
      ST_NEXT:   state_d = last_hyp ? ST_DONE : ST_CRESET;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_addr_d   = wr_addr_q;
    n_bins_d    = n_bins_q;
    strm_cnt_d  = strm_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    exp_d       = exp_q;
    step_d      = step_q;
    hyp_d       = hyp_q;
    best_hyp_d  = best_hyp_q;
    count_d     = count_q;
    hyp_idx_d   = hyp_idx_q;
    score_d     = score_q;
    best_corr_d = best_corr_q;
    flag_d      = flag_q;
    best_det_d  = best_det_q;
    timeout_d   = timeout_q;
    upd_d       = rd_en;
    case (state_q)
      ST_IDLE: wr_addr_d = '0;
      ST_LOAD: begin
        if (accept) begin
          wr_addr_d = wr_addr_q + AW'(1);
          if (wr_addr_q == '0) exp_d = s_mag_exp;
        end
        if (last_beat) begin
          n_bins_d    = {1'b0, wr_addr_q} + NW'(1);
          step_d      = {sweep_step_int, sweep_step_frac};
          count_d     = sweep_count;
          hyp_d       = {sweep_start_int, sweep_start_frac};
          best_hyp_d  = {sweep_start_int, sweep_start_frac};
          hyp_idx_d   = '0;
          best_corr_d = '0;
          best_det_d  = 1'b0;
          rst_cnt_d   = '0;
        end
      end
      ST_CRESET: begin
        rst_cnt_d  = (rst_cnt_q == RCW'(RESET_CYCLES - 1)) ? '0 : rst_cnt_q + RCW'(1);
        strm_cnt_d = '0;
      end
      ST_STREAM: begin
        strm_cnt_d = strm_cnt_q + NW'(1);
        to_cnt_d   = '0;
      end
      ST_WAIT: begin
        if (correlation_in_valid) begin
          score_d = correlation_in[MW-1:0];
          flag_d  = correlation_in[MW];
        end else if (to_expired) begin
          score_d   = '0;
          flag_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      ST_NEXT: begin
        // Strict compare so that ties keep the earliest hypothesis.
        if (score_q > best_corr_q) begin
          best_corr_d = score_q;
          best_det_d  = flag_q;
          best_hyp_d  = hyp_q;
        end
        hyp_d     = hyp_q + step_q;
        hyp_idx_d = hyp_idx_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_mag_tready      = (state_q == ST_LOAD);
    correlation_reset = (state_q == ST_CRESET);
    result_valid      = (state_q == ST_DONE);
    busy              = (state_q != ST_IDLE);
  end

  assign sfo_int_part         = hyp_q[HW-1:SFO_FRAC_WIDTH];
  assign sfo_frac_part        = hyp_q[SFO_FRAC_WIDTH-1:0];
  assign correlation_update   = upd_q;
  assign fft_mag_out          = mag_q;
  assign fft_mag_exponent_out = exp_q;
  assign best_sfo_int         = best_hyp_q[HW-1:SFO_FRAC_WIDTH];
  assign best_sfo_frac        = best_hyp_q[SFO_FRAC_WIDTH-1:0];
  assign best_corr            = best_corr_q;
  assign best_detected        = best_det_q;
  assign timeout_err          = timeout_q;

endmodule

// File: tb/tb_sfo_sweep_controller.sv
// Bench for sfo_sweep_controller: a behavioural correlator responder plus directed
// and randomized sweeps, each checked against expectations built from the frame/scores.
module tb_sfo_sweep_controller;
  localparam int LOG2 = 4;
  localparam int RC   = 2;
  localparam int TO   = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_mag_tdata;
  logic [3:0]  s_mag_exp;
  logic        s_mag_tvalid, s_mag_tlast, s_mag_tready;
  logic [7:0]  sweep_start_int, sweep_start_frac, sweep_step_int, sweep_step_frac;
  logic [15:0] sweep_count;
  logic [7:0]  sfo_int_part, sfo_frac_part;
  logic        correlation_reset, correlation_update;
  logic [15:0] fft_mag_out;
  logic [3:0]  fft_mag_exponent_out;
  logic [24:0] correlation_in;
  logic        correlation_in_valid;
  logic [7:0]  best_sfo_int, best_sfo_frac;
  logic [23:0] best_corr;
  logic        best_detected, result_valid, busy, timeout_err;

  sfo_sweep_controller #(
    .FFT_LEN_LOG2(LOG2), .POWER_WIDTH(16), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO),
    .SFO_INT_WIDTH(8), .SFO_FRAC_WIDTH(8), .FFT_SHIFT_WIDTH(4), .CORR_MANTISSA_WIDTH(24)
  ) dut (
    .clk(clk), .reset(reset),
    .s_mag_tdata(s_mag_tdata), .s_mag_exp(s_mag_exp), .s_mag_tvalid(s_mag_tvalid),
    .s_mag_tlast(s_mag_tlast), .s_mag_tready(s_mag_tready),
    .sweep_start_int(sweep_start_int), .sweep_start_frac(sweep_start_frac),
    .sweep_step_int(sweep_step_int), .sweep_step_frac(sweep_step_frac),
    .sweep_count(sweep_count),
    .sfo_int_part(sfo_int_part), .sfo_frac_part(sfo_frac_part),
    .correlation_reset(correlation_reset), .correlation_update(correlation_update),
    .fft_mag_out(fft_mag_out), .fft_mag_exponent_out(fft_mag_exponent_out),
    .correlation_in(correlation_in), .correlation_in_valid(correlation_in_valid),
    .best_sfo_int(best_sfo_int), .best_sfo_frac(best_sfo_frac), .best_corr(best_corr),
    .best_detected(best_detected), .result_valid(result_valid), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] frame [16];
  logic [24:0] resp_val [16];
  bit          resp_en [16];
  int          resp_delay = 10;
  int          hyp_seen = 0;
  int          base = 0;
  logic [15:0] obs_mag [$];
  logic [15:0] obs_hyp [$];
  int          cr_len [$];
  int          gap_cnt = 0;
  int          instab = 0;
  int          results = 0;
  int          rv_long = 0;
  logic [15:0] r_hyp;
  logic [23:0] r_corr;
  logic        r_det;

  // Correlator stand-in: observes the feeder side and answers after resp_delay cycles.
  initial begin : corr_model
    bit prev_cr, prev_upd, started, prev_rv;
    int run, cd, hi;
    logic [15:0] cur_hyp;
    prev_cr = 0; prev_upd = 0; started = 0; prev_rv = 0; run = 0; cd = 0; cur_hyp = '0;
    correlation_in_valid = 1'b0;
    correlation_in = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        correlation_in_valid = 1'b0; correlation_in = '0;
        cd = 0; prev_cr = 0; prev_upd = 0; prev_rv = 0; run = 0; started = 0;
        continue;
      end
      if (correlation_reset) begin
        if (!prev_cr) begin
          hyp_seen++;
          cur_hyp = {sfo_int_part, sfo_frac_part};
          obs_hyp.push_back(cur_hyp);
          run = 0; started = 0; cd = 0;
          correlation_in_valid = 1'b0; correlation_in = '0;
        end
        run++;
      end else if (prev_cr) begin
        cr_len.push_back(run);
      end
      if ((correlation_reset || correlation_update) && ({sfo_int_part, sfo_frac_part} !== cur_hyp))
        instab++;
      if (correlation_update) begin
        obs_mag.push_back(fft_mag_out);
        if (!prev_upd) begin
          if (started) gap_cnt++;
          started = 1;
        end
      end
      if (prev_upd && !correlation_update) begin
        cd = resp_delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          hi = hyp_seen - 1 - base;
          if (hi < 0) hi = 0;
          if (hi > 15) hi = 15;
          correlation_in = resp_val[hi];
          correlation_in_valid = resp_en[hi];
        end
      end
      if (result_valid) begin
        results++;
        r_hyp = {best_sfo_int, best_sfo_frac};
        r_corr = best_corr;
        r_det = best_detected;
        if (prev_rv) rv_long++;
      end
      prev_cr = correlation_reset;
      prev_upd = correlation_update;
      prev_rv = result_valid;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {s_mag_tready, correlation_reset, correlation_update, fft_mag_out,
              fft_mag_exponent_out, sfo_int_part, sfo_frac_part, best_sfo_int,
              best_sfo_frac, best_corr, best_detected, result_valid, busy, timeout_err},
        64'd0);
  endtask

  task automatic clr_resp();
    for (int i = 0; i < 16; i++) begin
      resp_en[i] = 1'b0;
      resp_val[i] = '0;
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) frame[i] = 16'($urandom);
  endtask

  task automatic send_frame(input string tag, input int n, input bit use_last,
                            input logic [15:0] start, input logic [15:0] step,
                            input int cnt, input logic [3:0] e_exp);
    int g, errs;
    {sweep_start_int, sweep_start_frac} = start;
    {sweep_step_int, sweep_step_frac}   = step;
    sweep_count = 16'(cnt);
    for (int i = 0; i < n; i++) begin
      s_mag_tvalid = 1'b1;
      s_mag_tdata  = frame[i];
      s_mag_exp    = (i == 0) ? e_exp : 4'($urandom);
      s_mag_tlast  = use_last && (i == n - 1);
      g = 0;
      while (!s_mag_tready && g < 64) begin @(negedge clk); g++; end
      if (g >= 64) chk({tag, "_tready_wait"}, 0, 1);
      @(negedge clk);
    end
    s_mag_tlast = 1'b0;
    {sweep_start_int, sweep_start_frac, sweep_step_int, sweep_step_frac} = 32'($urandom);
    sweep_count = 16'($urandom);
    if (use_last) begin
      s_mag_tvalid = 1'b0;
      chk({tag, "_tready_drop"}, s_mag_tready, 0);
    end else begin
      errs = 0;
      s_mag_tdata = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
        if (s_mag_tready !== 1'b0) errs++;
        @(negedge clk);
      end
      s_mag_tvalid = 1'b0;
      chk({tag, "_tready_full"}, errs, 0);
    end
  endtask

  task automatic sweep(input string tag, input int n, input bit use_last,
                       input logic [15:0] start, input logic [15:0] step, input int cnt);
    int m0, h0, c0, r0, g0, i0, errs, g, bi, idx;
    logic [3:0]  e_exp;
    logic [23:0] best, sc;
    logic        bflag;
    logic [15:0] eh;
    m0 = obs_mag.size(); h0 = obs_hyp.size(); c0 = cr_len.size();
    r0 = results; g0 = gap_cnt; i0 = instab;
    base = hyp_seen;
    e_exp = 4'($urandom);
    send_frame(tag, n, use_last, start, step, cnt, e_exp);
    if (cnt == 0) chk({tag, "_rv_immediate"}, result_valid, 1);
    chk({tag, "_exp"}, fft_mag_exponent_out, e_exp);
    g = 0;
    while (results == r0 && g < 3000) begin @(negedge clk); g++; end
    chk({tag, "_done"}, results - r0, 1);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, result_valid}, 2'b00);
    chk({tag, "_nupd"}, obs_mag.size() - m0, n * cnt);
    errs = 0;
    for (int h = 0; h < cnt; h++)
      for (int k = 0; k < n; k++) begin
        idx = m0 + h * n + k;
        if (idx >= obs_mag.size() || obs_mag[idx] !== frame[k]) errs++;
      end
    chk({tag, "_mags"}, errs, 0);
    chk({tag, "_nhyp"}, obs_hyp.size() - h0, cnt);
    errs = 0;
    for (int h = 0; h < cnt; h++) begin
      eh = start + 16'(h) * step;
      if (h0 + h >= obs_hyp.size() || obs_hyp[h0 + h] !== eh) errs++;
    end
    chk({tag, "_hyps"}, errs, 0);
    errs = 0;
    for (int i = c0; i < cr_len.size(); i++) if (cr_len[i] != RC) errs++;
    chk({tag, "_creset_len"}, errs, 0);
    chk({tag, "_gaps_instab"}, {32'(gap_cnt - g0), 32'(instab - i0)}, 64'd0);
    best = '0; bi = -1; bflag = 1'b0;
    for (int h = 0; h < cnt; h++) begin
      sc = resp_en[h] ? resp_val[h][23:0] : 24'd0;
      if (sc > best) begin
        best = sc; bi = h; bflag = resp_en[h] & resp_val[h][24];
      end
    end
    eh = (bi < 0) ? start : start + 16'(bi) * step;
    chk({tag, "_best_sfo"}, r_hyp, eh);
    chk({tag, "_best_corr"}, r_corr, best);
    chk({tag, "_best_det"}, r_det, bflag);
  endtask

  initial begin
    int g, cnt, n;
    bit found;
    reset = 1'b1;
    s_mag_tdata = '0; s_mag_exp = '0; s_mag_tvalid = 1'b0; s_mag_tlast = 1'b0;
    sweep_start_int = '0; sweep_start_frac = '0; sweep_step_int = '0; sweep_step_frac = '0;
    sweep_count = '0;
    clr_resp();
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    reset = 1'b0;

    rand_frame(); clr_resp();
    resp_en[0] = 1'b1; resp_val[0] = 25'h0123456;
    sweep("single", 16, 1'b1, 16'h0A40, 16'h0010, 1);
    chk("single_no_timeout", timeout_err, 0);

    rand_frame(); clr_resp();
    for (int i = 0; i < 2; i++) begin resp_en[i] = 1'b1; resp_val[i] = 25'($urandom); end
    sweep("short", 5, 1'b1, 16'h1000, 16'h0020, 2);

    rand_frame(); clr_resp();
    for (int i = 0; i < 4; i++) resp_en[i] = 1'b1;
    resp_val[0] = 25'd10; resp_val[1] = 25'd40;
    resp_val[2] = {1'b1, 24'd40}; resp_val[3] = 25'd20;
    sweep("four", 8, 1'b1, 16'h0300, 16'h0180, 4);
    chk("four_best_exact", {r_hyp, r_corr, r_det}, {16'h0480, 24'd40, 1'b0});

    rand_frame(); clr_resp();
    resp_en[0] = 1'b1; resp_val[0] = 25'd0;
    resp_en[1] = 1'b0; resp_val[1] = 25'h0FFFFFF;
    resp_en[2] = 1'b1; resp_val[2] = 25'd7;
    sweep("timeout", 4, 1'b1, 16'h2000, 16'h0100, 3);
    chk("timeout_err_set", timeout_err, 1);

    rand_frame(); clr_resp();
    sweep("zero_count", 3, 1'b1, 16'h5555, 16'h0101, 0);

    rand_frame(); clr_resp();
    for (int i = 0; i < 3; i++) begin resp_en[i] = 1'b1; resp_val[i] = 25'($urandom); end
    sweep("wrap", 2, 1'b1, 16'hFE80, 16'h0180, 3);

    rand_frame(); clr_resp();
    for (int i = 0; i < 2; i++) begin resp_en[i] = 1'b1; resp_val[i] = 25'($urandom_range(1, 99)); end
    sweep("full_no_tlast", 16, 1'b0, 16'h0700, 16'h0040, 2);

    for (int t = 0; t < 4; t++) begin
      rand_frame(); clr_resp();
      n = $urandom_range(1, 16);
      cnt = $urandom_range(1, 4);
      for (int i = 0; i < cnt; i++) begin
        resp_en[i] = 1'b1;
        resp_val[i] = {1'($urandom), 24'($urandom_range(0, 5))};
      end
      sweep($sformatf("rand%0d", t), n, 1'b1, 16'($urandom), 16'($urandom), cnt);
    end
    chk("timeout_sticky", timeout_err, 1);

    rand_frame(); clr_resp();
    for (int i = 0; i < 3; i++) begin resp_en[i] = 1'b1; resp_val[i] = 25'd3; end
    base = hyp_seen;
    send_frame("midrst", 6, 1'b1, 16'h0400, 16'h0100, 3, 4'h5);
    g = 0; found = 0;
    while (!found && g < 500) begin
      @(negedge clk); g++;
      if ((hyp_seen - base == 2) && correlation_update) found = 1;
    end
    chk("midrst_reach_stream2", found, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("midrst_outputs");
    reset = 1'b0;

    rand_frame(); clr_resp();
    resp_en[0] = 1'b1; resp_val[0] = {1'b1, 24'h000ABC};
    sweep("post_reset", 4, 1'b1, 16'h0C00, 16'h0100, 1);
    chk("rv_single_cycle", rv_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
